instr_encode: RTL and testbench

Streaming RV32I instruction encoder. It is the inverse of the opcode decode path: it takes an opcode_t kind plus instruction fields and produces a 32-bit instruction word. It is used by the debug/boot injector and by self-check benches to assemble instructions in hardware. A valid/ready input feeds a small output FIFO, and out-of-range fields are flagged per beat.

---
 rtl/instr_type.sv | 41 ++++
 rtl/instr_encode_pack.sv | 87 ++++++++
 rtl/instr_encode.sv | 104 ++++++++++
 tb/tb_instr_encode.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_type.sv
// Shared RV32I instruction-kind definitions. The decoder and the encoder
// both take their opcode constants from here.
package instr_type;

  typedef enum logic [3:0] {
    op_invalid   = 4'd0,
    op_lui       = 4'd1,
    op_auipc     = 4'd2,
    op_jal       = 4'd3,
    op_jalr      = 4'd4,
    op_branch    = 4'd5,
    op_load      = 4'd6,
    op_store     = 4'd7,
    op_imm_arith = 4'd8,
    op_reg_arith = 4'd9,
    op_fence     = 4'd10,
    op_system    = 4'd11
  } opcode_t;

  typedef enum logic [2:0] {
    fmt_r,
    fmt_i,
    fmt_s,
    fmt_b,
    fmt_u,
    fmt_j
  } instr_fmt_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

endpackage

// File: rtl/instr_encode_pack.sv
// Combinational RV32I field packer: picks the format for an instruction
// kind, scatters the immediate into place and flags out-of-range fields.
// An error beat always yields an all-zero word.
module instr_encode_pack
  import instr_type::*;
#(
  parameter bit CHECK_RANGE = 1'b1
) (
  input  opcode_t     kind_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [31:0] imm_i,
  output logic [31:0] instr_o,
  output logic        err_o
);

  instr_fmt_t  fmt;
  logic [6:0]  opc;
  logic        shamt_form;
  logic        range_bad;
  logic        kind_bad;
  logic [31:0] word;

  // Sign-extension checks: upper bits must all replicate the sign bit.
  logic fits12, fits13, fits21;
  assign fits12 = (&imm_i[31:11]) | ~(|imm_i[31:11]);
  assign fits13 = (&imm_i[31:12]) | ~(|imm_i[31:12]);
  assign fits21 = (&imm_i[31:20]) | ~(|imm_i[31:20]);

  // Map the instruction kind to format, major opcode and range verdict.
  always_comb begin
    fmt        = fmt_r;
    opc        = 7'd0;
    shamt_form = 1'b0;
    range_bad  = 1'b0;
    kind_bad   = 1'b0;
    case (kind_i)
      op_lui:       begin fmt = fmt_u; opc = OPC_LUI;    range_bad = |imm_i[11:0]; end
      op_auipc:     begin fmt = fmt_u; opc = OPC_AUIPC;  range_bad = |imm_i[11:0]; end
      op_jal:       begin fmt = fmt_j; opc = OPC_JAL;    range_bad = imm_i[0] | ~fits21; end
      op_jalr:      begin fmt = fmt_i; opc = OPC_JALR;   range_bad = ~fits12; end
      op_load:      begin fmt = fmt_i; opc = OPC_LOAD;   range_bad = ~fits12; end
      op_imm_arith: begin
        fmt = fmt_i;
        opc = OPC_OP_IMM;
        // SLLI/SRLI/SRAI carry funct7 in the upper bits and a 5-bit shamt.
        if (funct3_i == 3'b001 || funct3_i == 3'b101) begin
          shamt_form = 1'b1;
          range_bad  = |imm_i[31:5];
        end else begin
          range_bad  = ~fits12;
        end
      end
      op_fence:     begin fmt = fmt_i; opc = OPC_FENCE;  range_bad = |imm_i[31:12]; end
      op_system:    begin fmt = fmt_i; opc = OPC_SYSTEM; range_bad = |imm_i[31:12]; end
      op_store:     begin fmt = fmt_s; opc = OPC_STORE;  range_bad = ~fits12; end
      op_branch:    begin fmt = fmt_b; opc = OPC_BRANCH; range_bad = imm_i[0] | ~fits13; end
      op_reg_arith: begin fmt = fmt_r; opc = OPC_OP; end
      default:      kind_bad = 1'b1;
    endcase
  end

  // Scatter fields into the selected format and zero the word on error.
  always_comb begin
    word = 32'd0;
    case (fmt)
      fmt_u: word = {imm_i[31:12], rd_i, opc};
      fmt_j: word = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opc};
      fmt_i: begin
        if (shamt_form)
          word = {funct7_i, imm_i[4:0], rs1_i, funct3_i, rd_i, opc};
        else
          word = {imm_i[11:0], rs1_i, funct3_i, rd_i, opc};
      end
      fmt_s: word = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opc};
      fmt_b: word = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                     imm_i[4:1], imm_i[11], opc};
      default: word = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opc};
    endcase
    err_o   = CHECK_RANGE ? (range_bad | kind_bad) : 1'b0;
    instr_o = (kind_bad | err_o) ? 32'd0 : word;
  end

endmodule

// File: rtl/instr_encode.sv
// Streaming RV32I instruction encoder: valid/ready input, combinational
// packing, small registered output FIFO and a saturating error counter.
module instr_encode
  import instr_type::*;
#(
  parameter int unsigned DEPTH       = 2,
  parameter int unsigned CHECK_RANGE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  opcode_t     opcode_type,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_err,
  output logic [15:0] err_cnt
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [31:0]   instr_mem_q [DEPTH];
  logic          err_mem_q   [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   err_cnt_q, err_cnt_d;

  logic [31:0] enc_instr;
  logic        enc_err;
  logic        push, pop;

  instr_encode_pack #(
    .CHECK_RANGE (CHECK_RANGE != 0)
  ) u_pack (
    .kind_i   (opcode_type),
    .funct3_i (funct3),
    .funct7_i (funct7),
    .rd_i     (rd),
    .rs1_i    (rs1),
    .rs2_i    (rs2),
    .imm_i    (imm),
    .instr_o  (enc_instr),
    .err_o    (enc_err)
  );

  // Held in reset or full means no new beat; no bypass when full.
  assign in_ready  = rst & (cnt_q != FULL_CNT);
  assign out_valid = (cnt_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Head of the FIFO drives the outputs; an empty FIFO presents zeros.
  assign out_instr = out_valid ? instr_mem_q[rptr_q] : 32'd0;
  assign out_err   = out_valid ? err_mem_q[rptr_q]   : 1'b0;
  assign err_cnt   = err_cnt_q;

  // Next-state for pointers, occupancy and the saturating error count.
  always_comb begin
    wptr_d    = push ? wptr_q + 1'b1 : wptr_q;
    rptr_d    = pop  ? rptr_q + 1'b1 : rptr_q;
    cnt_d     = cnt_q;
    if (push && !pop)
      cnt_d = cnt_q + 1'b1;
    else if (!push && pop)
      cnt_d = cnt_q - 1'b1;
    err_cnt_d = err_cnt_q;
    if (push && enc_err && err_cnt_q != 16'hFFFF)
      err_cnt_d = err_cnt_q + 16'd1;
  end

  // Control state with synchronous active-low reset that drops buffered beats.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      cnt_q     <= '0;
      err_cnt_q <= '0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      cnt_q     <= cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // FIFO storage: write the encoded beat at the tail on accept.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem_q[wptr_q] <= enc_instr;
      err_mem_q[wptr_q]   <= enc_err;
    end
  end

endmodule

// File: tb/tb_instr_encode.sv
// Bench for instr_encode: directed encodings, error beats, back-pressure,
// mid-stream reset and a randomized phase checked against a reference model.
module tb_instr_encode;
  import instr_type::*;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  opcode_t     opcode_type;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;
  logic [15:0] err_cnt;

  always #5 clk = ~clk;

  instr_encode #(.DEPTH(DEPTH), .CHECK_RANGE(1)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .opcode_type (opcode_type),
    .funct3      (funct3),
    .funct7      (funct7),
    .rd          (rd),
    .rs1         (rs1),
    .rs2         (rs2),
    .imm         (imm),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_err     (out_err),
    .err_cnt     (err_cnt)
  );

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [32:0] mq[$];
  logic [15:0] m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference encoder written from the instruction-set rules with integer arithmetic.
  function automatic logic [32:0] ref_enc(input opcode_t k, input logic [2:0] f3,
                                          input logic [6:0] f7, input logic [4:0] d,
                                          input logic [4:0] s1, input logic [4:0] s2,
                                          input logic [31:0] im);
    int          s;
    logic        e;
    logic [31:0] w, rdv, r1, r2, fn3, fn7, itail;
    s     = $signed(im);
    e     = 1'b0;
    rdv   = 32'(d) << 7;
    r1    = 32'(s1) << 15;
    r2    = 32'(s2) << 20;
    fn3   = 32'(f3) << 12;
    fn7   = 32'(f7) << 25;
    itail = ((im & 32'hFFF) << 20) | r1 | fn3 | rdv;
    w     = 32'd0;
    case (k)
      op_lui:   begin e = (im & 32'hFFF) != 0; w = (im & 32'hFFFFF000) | rdv | 32'h37; end
      op_auipc: begin e = (im & 32'hFFF) != 0; w = (im & 32'hFFFFF000) | rdv | 32'h17; end
      op_jal: begin
        e = (s % 2 != 0) || (s < -1048576) || (s > 1048575);
        w = (((im >> 20) & 1) << 31) | (((im >> 1) & 32'h3FF) << 21) |
            (((im >> 11) & 1) << 20) | (((im >> 12) & 32'hFF) << 12) | rdv | 32'h6F;
      end
      op_jalr:  begin e = (s < -2048) || (s > 2047); w = itail | 32'h67; end
      op_load:  begin e = (s < -2048) || (s > 2047); w = itail | 32'h03; end
      op_imm_arith: begin
        if (f3 == 3'd1 || f3 == 3'd5) begin
          e = im > 31;
          w = fn7 | ((im & 32'h1F) << 20) | r1 | fn3 | rdv | 32'h13;
        end else begin
          e = (s < -2048) || (s > 2047);
          w = itail | 32'h13;
        end
      end
      op_fence:  begin e = im > 4095; w = itail | 32'h0F; end
      op_system: begin e = im > 4095; w = itail | 32'h73; end
      op_store: begin
        e = (s < -2048) || (s > 2047);
        w = (((im >> 5) & 32'h7F) << 25) | r2 | r1 | fn3 | ((im & 32'h1F) << 7) | 32'h23;
      end
      op_branch: begin
        e = (s % 2 != 0) || (s < -4096) || (s > 4095);
        w = (((im >> 12) & 1) << 31) | (((im >> 5) & 32'h3F) << 25) | r2 | r1 | fn3 |
            (((im >> 1) & 32'hF) << 8) | (((im >> 11) & 1) << 7) | 32'h63;
      end
      op_reg_arith: w = fn7 | r2 | r1 | fn3 | rdv | 32'h33;
      default: e = 1'b1;
    endcase
    if (e) w = 32'd0;
    return {e, w};
  endfunction

  // Advance one clock and update the model FIFO as the design should.
  task automatic tick();
    logic        do_push, do_pop;
    logic [32:0] b;
    do_push = in_valid && (rst === 1'b1) && (mq.size() < DEPTH);
    do_pop  = out_ready && (mq.size() > 0);
    b       = ref_enc(opcode_type, funct3, funct7, rd, rs1, rs2, imm);
    @(posedge clk);
    if (rst !== 1'b1) begin
      mq.delete();
      m_err = 16'd0;
    end else begin
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        mq.push_back(b);
        if (b[32] && m_err != 16'hFFFF) m_err = m_err + 16'd1;
      end
    end
    #1;
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".in_ready"}, 32'(in_ready), 32'((rst === 1'b1) && (mq.size() < DEPTH)));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(mq.size() > 0));
    chk({tag, ".err_cnt"}, 32'(err_cnt), 32'(m_err));
    if (mq.size() > 0) begin
      chk({tag, ".out_instr"}, out_instr, mq[0][31:0]);
      chk({tag, ".out_err"}, 32'(out_err), 32'(mq[0][32]));
    end
  endtask

  task automatic drive(input opcode_t k, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                       input logic [31:0] im);
    in_valid = 1'b1; opcode_type = k; funct3 = f3; funct7 = f7;
    rd = d; rs1 = s1; rs2 = s2; imm = im;
  endtask

  // One beat through an empty FIFO, checked against literal expectations.
  task automatic one(input string tag, input opcode_t k, input logic [2:0] f3,
                     input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                     input logic [31:0] im, input logic [31:0] exp_w,
                     input logic exp_e, input logic [15:0] exp_cnt);
    out_ready = 1'b1;
    drive(k, f3, 7'd0, d, s1, s2, im);
    tick();
    in_valid = 1'b0;
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".instr"}, out_instr, exp_w);
    chk({tag, ".err"}, 32'(out_err), 32'(exp_e));
    chk({tag, ".cnt"}, 32'(err_cnt), 32'(exp_cnt));
    check_state(tag);
    tick();
    check_state({tag, ".drain"});
  endtask

  initial begin
    logic [31:0] rimm;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    drive(op_invalid, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    in_valid = 1'b0;
    m_err = 16'd0;

    // Reset state
    tick(); tick();
    chk("rst.in_ready", 32'(in_ready), 32'd0);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.out_instr", out_instr, 32'd0);
    chk("rst.out_err", 32'(out_err), 32'd0);
    chk("rst.err_cnt", 32'(err_cnt), 32'd0);
    rst = 1'b1;
    #1;
    chk("post_rst.in_ready", 32'(in_ready), 32'd1);

    // Directed encodings
    one("addi", op_imm_arith, 3'd0, 5'd1, 5'd0, 5'd0, 32'd5, 32'h00500093, 1'b0, 16'd0);
    one("lui", op_lui, 3'd0, 5'd2, 5'd0, 5'd0, 32'h12345000, 32'h12345137, 1'b0, 16'd0);
    one("jal", op_jal, 3'd0, 5'd1, 5'd0, 5'd0, 32'd8, 32'h008000EF, 1'b0, 16'd0);
    one("beq", op_branch, 3'd0, 5'd0, 5'd1, 5'd2, -32'sd4, 32'hFE208EE3, 1'b0, 16'd0);
    one("sw", op_store, 3'd2, 5'd0, 5'd1, 5'd2, 32'd8, 32'h0020A423, 1'b0, 16'd0);

    // Error beats
    one("addi_2048", op_imm_arith, 3'd0, 5'd1, 5'd0, 5'd0, 32'd2048, 32'd0, 1'b1, 16'd1);
    one("beq_odd", op_branch, 3'd0, 5'd0, 5'd1, 5'd2, 32'd3, 32'd0, 1'b1, 16'd2);
    one("invalid", op_invalid, 3'd0, 5'd1, 5'd1, 5'd1, 32'd0, 32'd0, 1'b1, 16'd3);

    // Back-pressure: only DEPTH beats accepted, head held stable
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(op_imm_arith, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'(i + 1));
      tick();
      check_state("fill");
    end
    chk("full.in_ready", 32'(in_ready), 32'd0);
    chk("full.head", out_instr, 32'h00100093);
    in_valid = 1'b0;
    tick();
    chk("hold.head", out_instr, 32'h00100093);
    out_ready = 1'b1;
    #1;
    check_state("drain0");
    tick();
    chk("drain.second", out_instr, 32'h00200093);
    check_state("drain1");
    tick();
    chk("drain.empty", 32'(out_valid), 32'd0);

    // Reset with two beats buffered
    out_ready = 1'b0;
    drive(op_imm_arith, 3'd0, 7'd0, 5'd3, 5'd0, 5'd0, 32'd7);
    tick(); tick();
    in_valid = 1'b0;
    check_state("prerst");
    rst = 1'b0;
    tick();
    chk("midrst.out_valid", 32'(out_valid), 32'd0);
    chk("midrst.err_cnt", 32'(err_cnt), 32'd0);
    chk("midrst.in_ready", 32'(in_ready), 32'd0);
    rst = 1'b1;
    #1;
    one("addi_after_rst", op_imm_arith, 3'd0, 5'd1, 5'd0, 5'd0, 32'd5, 32'h00500093, 1'b0, 16'd0);

    // Randomized traffic against the reference model
    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(0, 4))
        0:       rimm = 32'($signed($urandom_range(0, 4095)) - 2048);
        1:       rimm = $urandom;
        2:       rimm = $urandom & 32'hFFFFF000;
        3:       rimm = $urandom_range(0, 63);
        default: rimm = 32'($signed($urandom_range(0, 8191)) - 4096) & 32'hFFFFFFFE;
      endcase
      drive(opcode_t'(4'($urandom_range(0, 11))), 3'($urandom), 7'($urandom),
            5'($urandom), 5'($urandom), 5'($urandom), rimm);
      in_valid  = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
      check_state("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
